// File: rtl/boss_jump_ctrl.sv
// boss_jump_ctrl: boss movement controller.
// The boss waits on the ground for a number of frame ticks. It then hops
// toward the player with the highest aggro, moves horizontally while
// airborne, and lands with a one-clock pulse and a jump-count increment.
// All motion advances only on frame_tick while game_active == 1.
// Optional feature macro: BOSS_ENRAGE_EN. When it is defined, the enrage
// input halves the ground wait and doubles the horizontal step. When it is
// undefined, enrage is ignored.
module boss_jump_ctrl #(
  parameter int NUM_PLAYERS = 2,
  parameter int XW          = 12,
  parameter int HOR_PIXELS  = 1024,
  parameter int VER_PIXELS  = 768,
  parameter int BOSS_LNG    = 64,
  parameter int BOSS_HGT    = 216,
  parameter int GROUND_Y    = VER_PIXELS - 52 - BOSS_HGT,
  parameter int START_X     = HOR_PIXELS - HOR_PIXELS / 4,
  parameter int X_MIN       = BOSS_LNG,
  parameter int X_MAX       = HOR_PIXELS - BOSS_LNG,
  parameter int JUMP_HEIGHT = 350,
  parameter int JUMP_SPEED  = 9,
  parameter int FALL_SPEED  = 9,
  parameter int MOVE_STEP   = 5,
  parameter int WAIT_TICKS  = 30
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_tick,
  input  logic [1:0]                game_active,
  input  logic [NUM_PLAYERS*XW-1:0] player_x,
  input  logic [NUM_PLAYERS*4-1:0]  player_aggro,
  input  logic                      enrage,
  output logic [XW-1:0]             boss_x,
  output logic [XW-1:0]             boss_y,
  output logic [1:0]                boss_state,
  output logic [2:0]                target_idx,
  output logic                      land_pulse,
  output logic [7:0]                jump_count
);

  // Movement phases; the encoding is also the boss_state output.
  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_RISE = 2'd1,
    ST_FALL = 2'd2
  } state_e;

  localparam int CW = (WAIT_TICKS < 1) ? 1 : $clog2(WAIT_TICKS + 1);

  // Constants widened to XW+1 bits so that comparisons and sums have room
  // for one carry bit.
  localparam logic [XW:0]   GROUND_W    = (XW+1)'(GROUND_Y);
  localparam logic [XW:0]   RISE_LIM_W  = (XW+1)'(GROUND_Y - JUMP_HEIGHT + JUMP_SPEED);
  localparam logic [XW:0]   X_MIN_W     = (XW+1)'(X_MIN);
  localparam logic [XW:0]   X_MAX_W     = (XW+1)'(X_MAX);
  localparam logic [XW:0]   FALL_W      = (XW+1)'(FALL_SPEED);
  localparam logic [XW-1:0] GROUND_X    = XW'(GROUND_Y);
  localparam logic [XW-1:0] START_XW    = XW'(START_X);
  localparam logic [XW-1:0] JUMP_XW     = XW'(JUMP_SPEED);
  localparam logic [XW-1:0] FALL_XW     = XW'(FALL_SPEED);

  // Registered state
  state_e          state_q;
  logic [XW-1:0]   boss_x_q;
  logic [XW-1:0]   boss_y_q;
  logic [CW-1:0]   wait_cnt_q;
  logic            dir_left_q;
  logic [XW-1:0]   target_x_q;
  logic [2:0]      target_idx_q;
  logic            land_pulse_q;
  logic [7:0]      jump_count_q;

  // Combinational helpers
  logic [3:0]      best_aggro_d;
  logic [2:0]      sel_idx_d;
  logic [XW-1:0]   sel_x_d;
  logic [XW:0]     step_d;
  logic [CW-1:0]   reload_d;
  logic [XW:0]     x_ext_d;
  logic [XW:0]     tx_ext_d;
  logic [XW:0]     x_mv_d;
  logic [XW-1:0]   boss_x_d;
  logic            rise_more_d;
  logic            fall_more_d;

  // Step size and wait reload. With enrage enabled, both are re-evaluated
  // each time they are used.
`ifdef BOSS_ENRAGE_EN
  always_comb begin
    step_d   = enrage ? (XW+1)'(2 * MOVE_STEP) : (XW+1)'(MOVE_STEP);
    reload_d = enrage ? CW'(WAIT_TICKS / 2) : CW'(WAIT_TICKS);
  end
`else
  logic unused_enrage;
  assign unused_enrage = enrage;

  always_comb begin
    step_d   = (XW+1)'(MOVE_STEP);
    reload_d = CW'(WAIT_TICKS);
  end
`endif

  // Target selection: highest aggro wins, and ties keep the lowest index.
  always_comb begin
    best_aggro_d = player_aggro[3:0];
    sel_idx_d    = 3'd0;
    sel_x_d      = player_x[XW-1:0];
    for (int i = 1; i < NUM_PLAYERS; i++) begin
      if (player_aggro[i*4 +: 4] > best_aggro_d) begin
        best_aggro_d = player_aggro[i*4 +: 4];
        sel_idx_d    = 3'(i);
        sel_x_d      = player_x[i*XW +: XW];
      end
    end
  end

  // Horizontal step toward the latched target. The step is clamped so it
  // never passes the target or the travel bounds. The subtraction is guarded
  // so it cannot wrap below zero.
  always_comb begin
    x_ext_d  = {1'b0, boss_x_q};
    tx_ext_d = {1'b0, target_x_q};
    if (dir_left_q) begin
      x_mv_d = (x_ext_d >= step_d) ? (x_ext_d - step_d) : '0;
      if (tx_ext_d > x_mv_d) x_mv_d = tx_ext_d;
      if (X_MIN_W > x_mv_d)  x_mv_d = X_MIN_W;
    end else begin
      x_mv_d = x_ext_d + step_d;
      if (tx_ext_d < x_mv_d) x_mv_d = tx_ext_d;
      if (X_MAX_W < x_mv_d)  x_mv_d = X_MAX_W;
    end
    boss_x_d = x_mv_d[XW-1:0];
  end

  // Vertical decisions: whether another full rise or fall step still fits.
  always_comb begin
    rise_more_d = ({1'b0, boss_y_q} > RISE_LIM_W);
    fall_more_d = (({1'b0, boss_y_q} + FALL_W) < GROUND_W);
  end

  // Movement FSM. All outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst || game_active == 2'd0) begin
      state_q      <= ST_WAIT;
      boss_x_q     <= START_XW;
      boss_y_q     <= GROUND_X;
      wait_cnt_q   <= '0;
      dir_left_q   <= 1'b0;
      target_x_q   <= START_XW;
      target_idx_q <= 3'd0;
      land_pulse_q <= 1'b0;
      jump_count_q <= 8'd0;
    end else if (game_active != 2'd1) begin
      // While frozen, every register holds except the landing pulse.
      land_pulse_q <= 1'b0;
    end else begin
      land_pulse_q <= 1'b0;
      if (frame_tick) begin
        case (state_q)
          ST_WAIT: begin
            if (wait_cnt_q != '0) begin
              wait_cnt_q <= wait_cnt_q - 1'b1;
            end else begin
              state_q      <= ST_RISE;
              target_x_q   <= sel_x_d;
              target_idx_q <= sel_idx_d;
              dir_left_q   <= (sel_x_d < boss_x_q);
              wait_cnt_q   <= reload_d;
            end
          end
          ST_RISE: begin
            boss_x_q <= boss_x_d;
            if (rise_more_d) boss_y_q <= boss_y_q - JUMP_XW;
            else             state_q  <= ST_FALL;
          end
          ST_FALL: begin
            boss_x_q <= boss_x_d;
            if (fall_more_d) begin
              boss_y_q <= boss_y_q + FALL_XW;
            end else begin
              boss_y_q     <= GROUND_X;
              state_q      <= ST_WAIT;
              wait_cnt_q   <= reload_d;
              land_pulse_q <= 1'b1;
              jump_count_q <= jump_count_q + 8'd1;
            end
          end
          default: state_q <= ST_WAIT;
        endcase
      end
    end
  end

  assign boss_x     = boss_x_q;
  assign boss_y     = boss_y_q;
  assign boss_state = state_q;
  assign target_idx = target_idx_q;
  assign land_pulse = land_pulse_q;
  assign jump_count = jump_count_q;

endmodule
